victim_ctrl: RTL and testbench

VICTIM_CTRL -- requirements
Module: victim_ctrl

---
 rtl/victim_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_victim_ctrl.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/victim_ctrl.sv
// Victim buffer controller: fully associative tag/state store between L1 and memory.
// Line data lives in an external array; this block steers it and sequences writeback/fill.
module victim_ctrl #(
  parameter int WAYS   = 8,
  parameter int LINE_W = 256,
  parameter int TAG_W  = 11
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     l1_req,
  input  logic [15:0]              l1_addr,
  input  logic                     l1_evict_valid,
  input  logic                     l1_evict_dirty,
  input  logic [15:0]              l1_evict_addr,
  input  logic [LINE_W-1:0]        l1_evict_data,
  output logic                     l1_resp,
  output logic [LINE_W-1:0]        l1_rdata,
  output logic                     l1_rdirty,
  output logic                     arr_load,
  output logic [$clog2(WAYS)-1:0]  arr_index,
  output logic [LINE_W-1:0]        arr_wdata,
  input  logic [LINE_W-1:0]        arr_rdata,
  output logic                     pmem_read,
  output logic                     pmem_write,
  output logic [15:0]              pmem_address,
  output logic [LINE_W-1:0]        pmem_wdata,
  input  logic [LINE_W-1:0]        pmem_rdata,
  input  logic                     pmem_resp
);
  localparam int IDX_W = $clog2(WAYS);
  localparam int OFS_W = 16 - TAG_W;

  typedef enum logic [2:0] {IDLE, COMPARE, SWAP, WB, FETCH, RESP} state_t;

  state_t              r_state;
  state_t              w_next;
  logic [WAYS-1:0]     r_valid;
  logic [WAYS-1:0]     r_dirty;
  logic [TAG_W-1:0]    r_tag [WAYS];
  logic [IDX_W-1:0]    r_age [WAYS];
  logic [TAG_W-1:0]    r_line;
  logic                r_ev_valid;
  logic                r_ev_dirty;
  logic [TAG_W-1:0]    r_ev_tag;
  logic [LINE_W-1:0]   r_ev_data;
  logic [IDX_W-1:0]    r_way;
  logic [LINE_W-1:0]   r_fill;

  logic                w_hit;
  logic [IDX_W-1:0]    w_hit_way;
  logic                w_inv_found;
  logic [IDX_W-1:0]    w_inv_way;
  logic [IDX_W-1:0]    w_old_way;
  logic [IDX_W-1:0]    w_tgt;
  logic                w_upd;
  logic                w_touch;
  logic                w_inv;
  logic                w_unused;

  assign w_unused = ^{l1_addr[OFS_W-1:0], l1_evict_addr[OFS_W-1:0]};

  // Descending scan so the lowest-index match / invalid way wins.
  always_comb begin
    w_hit       = 1'b0;
    w_hit_way   = '0;
    w_inv_found = 1'b0;
    w_inv_way   = '0;
    w_old_way   = '0;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (r_valid[i] && (r_tag[i] == r_line)) begin
        w_hit     = 1'b1;
        w_hit_way = IDX_W'(i);
      end
      if (!r_valid[i]) begin
        w_inv_found = 1'b1;
        w_inv_way   = IDX_W'(i);
      end
      if (r_age[i] == IDX_W'(WAYS - 1)) w_old_way = IDX_W'(i);
    end
    w_tgt = w_inv_found ? w_inv_way : w_old_way;
  end

  always_comb begin
    w_next       = r_state;
    l1_resp      = 1'b0;
    l1_rdata     = '0;
    l1_rdirty    = 1'b0;
    arr_load     = 1'b0;
    arr_index    = '0;
    arr_wdata    = '0;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = '0;
    pmem_wdata   = '0;
    w_upd        = 1'b0;
    w_touch      = 1'b0;
    w_inv        = 1'b0;
    case (r_state)
      IDLE: begin
        if (l1_req) w_next = COMPARE;
      end
      COMPARE: begin
        if (w_hit) begin
          arr_index = w_hit_way;
          w_next    = SWAP;
        end else if (r_valid[w_tgt] && r_dirty[w_tgt]) begin
          w_next = WB;
        end else begin
          w_next = FETCH;
        end
      end
      SWAP: begin
        l1_resp   = 1'b1;
        arr_index = r_way;
        l1_rdata  = arr_rdata;
        l1_rdirty = r_dirty[r_way];
        if (r_ev_valid) begin
          arr_load  = 1'b1;
          arr_wdata = r_ev_data;
          w_upd     = 1'b1;
          w_touch   = 1'b1;
        end else begin
          w_inv = 1'b1;
        end
        w_next = IDLE;
      end
      WB: begin
        pmem_write   = 1'b1;
        arr_index    = r_way;
        pmem_address = {r_tag[r_way], {OFS_W{1'b0}}};
        pmem_wdata   = arr_rdata;
        if (pmem_resp) w_next = FETCH;
      end
      FETCH: begin
        pmem_read    = 1'b1;
        pmem_address = {r_line, {OFS_W{1'b0}}};
        if (pmem_resp) w_next = RESP;
      end
      RESP: begin
        l1_resp  = 1'b1;
        l1_rdata = r_fill;
        if (r_ev_valid) begin
          arr_load  = 1'b1;
          arr_index = r_way;
          arr_wdata = r_ev_data;
          w_upd     = 1'b1;
          w_touch   = 1'b1;
        end
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_valid    <= '0;
      r_dirty    <= '0;
      r_line     <= '0;
      r_ev_valid <= 1'b0;
      r_ev_dirty <= 1'b0;
      r_ev_tag   <= '0;
      r_ev_data  <= '0;
      r_way      <= '0;
      r_fill     <= '0;
      for (int i = 0; i < WAYS; i++) begin
        r_tag[i] <= '0;
        r_age[i] <= IDX_W'(i);
      end
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && l1_req) begin
        r_line     <= l1_addr[15 -: TAG_W];
        r_ev_valid <= l1_evict_valid;
        r_ev_dirty <= l1_evict_dirty;
        r_ev_tag   <= l1_evict_addr[15 -: TAG_W];
        r_ev_data  <= l1_evict_data;
      end
      if (r_state == COMPARE) r_way <= w_hit ? w_hit_way : w_tgt;
      if (r_state == FETCH && pmem_resp) r_fill <= pmem_rdata;
      if (w_upd) begin
        r_valid[r_way] <= 1'b1;
        r_dirty[r_way] <= r_ev_dirty;
        r_tag[r_way]   <= r_ev_tag;
      end
      if (w_inv) begin
        r_valid[r_way] <= 1'b0;
        r_dirty[r_way] <= 1'b0;
      end
      // Ages younger than the touched way slide up one, keeping a permutation.
      if (w_touch) begin
        for (int i = 0; i < WAYS; i++) begin
          if (r_age[i] < r_age[r_way]) r_age[i] <= r_age[i] + 1'b1;
        end
        r_age[r_way] <= '0;
      end
    end
  end
endmodule

// File: tb/tb_victim_ctrl.sv
// Bench for victim_ctrl: recency-list reference model, response/memory scoreboards,
// directed corner cases followed by randomized traffic.
module tb_victim_ctrl;
  logic         clk = 1'b0;
  logic         rst;
  logic         l1_req;
  logic [15:0]  l1_addr;
  logic         l1_evict_valid;
  logic         l1_evict_dirty;
  logic [15:0]  l1_evict_addr;
  logic [255:0] l1_evict_data;
  logic         l1_resp;
  logic [255:0] l1_rdata;
  logic         l1_rdirty;
  logic         arr_load;
  logic [2:0]   arr_index;
  logic [255:0] arr_wdata;
  logic [255:0] arr_rdata;
  logic         pmem_read;
  logic         pmem_write;
  logic [15:0]  pmem_address;
  logic [255:0] pmem_wdata;
  logic [255:0] pmem_rdata;
  logic         pmem_resp;

  always #5 clk = ~clk;

  victim_ctrl #(.WAYS(8), .LINE_W(256), .TAG_W(11)) dut (
    .clk(clk), .rst(rst), .l1_req(l1_req), .l1_addr(l1_addr),
    .l1_evict_valid(l1_evict_valid), .l1_evict_dirty(l1_evict_dirty),
    .l1_evict_addr(l1_evict_addr), .l1_evict_data(l1_evict_data),
    .l1_resp(l1_resp), .l1_rdata(l1_rdata), .l1_rdirty(l1_rdirty),
    .arr_load(arr_load), .arr_index(arr_index), .arr_wdata(arr_wdata), .arr_rdata(arr_rdata),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  // External victim data array
  logic [255:0] arr [8];
  assign arr_rdata = arr[arr_index];
  always @(posedge clk) if (arr_load) arr[arr_index] <= arr_wdata;

  int checks = 0;
  int errors = 0;
  bit hold = 1'b0;

  typedef struct { logic [255:0] data; logic dirty; } resp_t;
  typedef struct { logic wr; logic [15:0] addr; logic [255:0] data; } pm_t;
  resp_t exp_resp[$];
  pm_t   exp_pm[$];

  // Reference model: entries plus a recency list (front = most recently inserted/swapped)
  bit           m_valid [8];
  bit           m_dirty [8];
  logic [10:0]  m_tag   [8];
  logic [255:0] m_data  [8];
  int           m_lru[$];
  logic [255:0] m_mem   [int];
  logic [255:0] env_mem [int];

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic finish_sim();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  endtask

  function automatic logic [255:0] mem_init(input logic [10:0] line);
    logic [31:0] w;
    w = ({21'h0, line} * 32'h9E3779B1) ^ 32'h5A5A0000;
    return {8{w}};
  endfunction

  function automatic logic [255:0] rnd256();
    logic [255:0] v;
    for (int k = 0; k < 8; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic void model_reset();
    m_lru.delete();
    for (int w = 0; w < 8; w++) begin
      m_valid[w] = 1'b0;
      m_dirty[w] = 1'b0;
      m_tag[w]   = '0;
      m_lru.push_back(w);
    end
  endfunction

  function automatic void touch(input int w);
    int idx = 0;
    for (int k = 0; k < m_lru.size(); k++) if (m_lru[k] == w) idx = k;
    m_lru.delete(idx);
    m_lru.push_front(w);
  endfunction

  function automatic int model_find(input logic [10:0] line);
    for (int w = 0; w < 8; w++) if (m_valid[w] && m_tag[w] == line) return w;
    return -1;
  endfunction

  function automatic int model_age(input int w);
    for (int k = 0; k < m_lru.size(); k++) if (m_lru[k] == w) return k;
    return -1;
  endfunction

  // Response scoreboard
  always @(negedge clk) begin
    resp_t r;
    if (l1_resp) begin
      if (exp_resp.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL l1_resp_unexpected: got resp with no pending request");
      end else begin
        r = exp_resp.pop_front();
        chk("l1_rdata", l1_rdata, r.data);
        chk("l1_rdirty", l1_rdirty, r.dirty);
      end
    end
  end

  // Per-cycle invariants: exclusive pmem strobes, ages a permutation of 0..7
  always @(negedge clk) begin
    logic [7:0] seen;
    if (!rst) begin
      chk("pmem_rw_exclusive", pmem_read & pmem_write, 1'b0);
      seen = '0;
      for (int i = 0; i < 8; i++) seen[dut.r_age[i]] = 1'b1;
      chk("age_permutation", seen, 8'hFF);
    end
  end

  // Memory responder and memory-traffic scoreboard
  initial begin
    pm_t p;
    logic [10:0] ln;
    pmem_resp  = 1'b0;
    pmem_rdata = '0;
    forever begin
      @(negedge clk);
      if (!rst && !hold && (pmem_read || pmem_write)) begin
        ln = pmem_address[15:5];
        if (exp_pm.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL pmem_unexpected: got rd=%0b wr=%0b addr %h", pmem_read, pmem_write, pmem_address);
        end else begin
          p = exp_pm.pop_front();
          chk("pmem_is_write", pmem_write, p.wr);
          chk("pmem_address", pmem_address, p.addr);
          if (p.wr) chk("pmem_wdata", pmem_wdata, p.data);
        end
        repeat ($urandom_range(0, 3)) @(negedge clk);
        if (pmem_write) env_mem[int'(ln)] = pmem_wdata;
        else pmem_rdata = env_mem.exists(int'(ln)) ? env_mem[int'(ln)] : mem_init(ln);
        pmem_resp = 1'b1;
        @(negedge clk);
        pmem_resp = 1'b0;
      end
    end
  end

  task automatic do_req(input logic [15:0] addr, input bit evv, input bit evd,
                        input logic [15:0] evaddr, input logic [255:0] evdata);
    logic [10:0]  line;
    logic [255:0] fill;
    int           hw;
    int           t;
    int           cyc;
    int           loads;
    line = addr[15:5];
    hw   = model_find(line);
    if (hw >= 0) begin
      exp_resp.push_back('{m_data[hw], m_dirty[hw]});
      t = hw;
      if (!evv) begin
        m_valid[hw] = 1'b0;
        m_dirty[hw] = 1'b0;
      end
    end else begin
      t = -1;
      for (int w = 7; w >= 0; w--) if (!m_valid[w]) t = w;
      if (t < 0) t = m_lru[7];
      if (m_valid[t] && m_dirty[t]) begin
        exp_pm.push_back('{1'b1, {m_tag[t], 5'b0}, m_data[t]});
        m_mem[int'(m_tag[t])] = m_data[t];
      end
      exp_pm.push_back('{1'b0, {line, 5'b0}, 256'h0});
      fill = m_mem.exists(int'(line)) ? m_mem[int'(line)] : mem_init(line);
      exp_resp.push_back('{fill, 1'b0});
    end
    if (evv) begin
      m_valid[t] = 1'b1;
      m_dirty[t] = evd;
      m_tag[t]   = evaddr[15:5];
      m_data[t]  = evdata;
      touch(t);
    end

    @(negedge clk);
    l1_addr        = addr;
    l1_evict_valid = evv;
    l1_evict_dirty = evd;
    l1_evict_addr  = evaddr;
    l1_evict_data  = evdata;
    l1_req         = 1'b1;
    cyc   = 0;
    loads = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (arr_load) loads++;
    end while (!l1_resp && cyc < 300);
    l1_req = 1'b0;
    if (!l1_resp) begin
      errors++;
      $display("FAIL l1_resp_timeout: got no resp within %0d cycles for addr %h", cyc, addr);
      finish_sim();
    end
    if (hw >= 0) chk("hit_latency", cyc, 2);
    chk("arr_load_count", loads, evv);
    chk("pmem_ops_done", exp_pm.size(), 0);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    exp_resp.delete();
    exp_pm.delete();
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [15:0]  a;
    logic [15:0]  ea;
    logic [255:0] d;
    bit           ev;
    int           cyc;
    l1_req = 1'b0; l1_addr = '0; l1_evict_valid = 1'b0; l1_evict_dirty = 1'b0;
    l1_evict_addr = '0; l1_evict_data = '0;
    rst = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_l1_resp", l1_resp, 1'b0);
    chk("rst_arr_load", arr_load, 1'b0);
    chk("rst_pmem_read", pmem_read, 1'b0);
    chk("rst_pmem_write", pmem_write, 1'b0);
    chk("rst_valid", dut.r_valid, 8'h00);
    for (int i = 0; i < 8; i++) chk("rst_age", dut.r_age[i], i);
    rst = 1'b0;

    // Cold miss, no evict
    do_req(16'h1240, 1'b0, 1'b0, 16'h0, '0);
    // Insert clean 0x3000 on miss, then hit it
    d = rnd256();
    do_req(16'h2000, 1'b1, 1'b0, 16'h3000, d);
    chk("insert_tag0", dut.r_tag[0], 11'h180);
    chk("insert_valid0", dut.r_valid[0], 1'b1);
    do_req(16'h3004, 1'b0, 1'b0, 16'h0, '0);

    // Fill all ways (way3 and way5 dirty), age way3 to oldest, then dirty replace
    do_reset();
    for (int k = 0; k < 8; k++)
      do_req(16'h5000 + 16'(k * 32), 1'b1, (k == 3 || k == 5), 16'h6000 + 16'(k * 32), rnd256());
    for (int k = 0; k < 3; k++)
      do_req(16'h6000 + 16'(k * 32), 1'b1, 1'b0, 16'h7000 + 16'(k * 32), rnd256());
    chk("way3_oldest", dut.r_age[3], 3'd7);
    do_req(16'h5800, 1'b1, 1'b0, 16'h7800, rnd256());
    chk("replace_tag3", dut.r_tag[3], 11'h3C0);

    // Hit on dirty way5 while evicting 0x4A00
    do_req(16'h60A0, 1'b1, 1'b0, 16'h4A00, rnd256());
    chk("swap_tag5", dut.r_tag[5], 11'h250);
    chk("swap_age5", dut.r_age[5], 3'd0);
    chk("model_age5", model_age(5), 0);

    // Randomized traffic over a small line pool so hits and replacements recur
    for (int n = 0; n < 250; n++) begin
      a  = {5'h08 + 5'($urandom_range(0, 2)), 6'($urandom_range(0, 7)), 5'($urandom_range(0, 31))};
      ev = ($urandom_range(0, 3) != 0);
      ea = '0;
      if (ev) begin
        ev = 1'b0;
        for (int tries = 0; tries < 40 && !ev; tries++) begin
          ea = {5'h08 + 5'($urandom_range(0, 2)), 6'($urandom_range(0, 7)), 5'd0};
          if (ea[15:5] != a[15:5] && model_find(ea[15:5]) < 0) ev = 1'b1;
        end
      end
      do_req(a, ev, 1'($urandom_range(0, 1)), ea, rnd256());
    end

    // Reset while a fill is outstanding and memory never answers
    do_reset();
    hold = 1'b1;
    @(negedge clk);
    l1_addr = 16'h1240; l1_evict_valid = 1'b0; l1_req = 1'b1;
    cyc = 0;
    while (!pmem_read && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk("fetch_started", pmem_read, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("abort_pmem_read", pmem_read, 1'b0);
    chk("abort_l1_resp", l1_resp, 1'b0);
    chk("abort_state_idle", dut.r_state, 0);
    chk("abort_valid", dut.r_valid, 8'h00);
    l1_req = 1'b0;
    @(negedge clk);
    rst  = 1'b0;
    hold = 1'b0;
    exp_resp.delete();
    exp_pm.delete();
    model_reset();
    do_req(16'h1240, 1'b1, 1'b1, 16'h3000, rnd256());
    chk("post_abort_valid0", dut.r_valid[0], 1'b1);

    repeat (3) @(negedge clk);
    chk("resp_queue_drained", exp_resp.size(), 0);
    finish_sim();
  end

  initial begin
    #1000000;
    errors++;
    $display("FAIL watchdog: got no completion by time limit");
    finish_sim();
  end
endmodule
